// File: rtl/branch_predictor_bht_pkg.sv
// Shared types and helpers for the BHT/BTB branch predictor.
//   bp_state_e   : sweep/run state of the table controller
//   ctr_weak_t   : weakly-taken counter value for a given counter width
//   ctr_weak_nt  : weakly-not-taken counter value (one below weakly-taken)
package branch_predictor_bht_pkg;

   typedef enum logic [0:0] {
      StInit,
      StRun
   } bp_state_e;

   function automatic int unsigned ctr_weak_t(input int unsigned ctr_bits);
      return 32'd1 << (ctr_bits - 1);
   endfunction

   function automatic int unsigned ctr_weak_nt(input int unsigned ctr_bits);
      return ctr_weak_t(ctr_bits) - 32'd1;
   endfunction

endpackage

// File: rtl/branch_predictor_bht_sat_counter.sv
// Saturating up/down counter step (combinational).
//   ctr_i : current counter value
//   inc_i : 1 = count up, 0 = count down
//   en_i  : 0 passes ctr_i through unchanged
//   ctr_o : next counter value, held at all-ones / zero
module branch_predictor_bht_sat_counter #(
   parameter int unsigned CTR_BITS = 2
) (
   input  logic [CTR_BITS-1:0] ctr_i,
   input  logic                inc_i,
   input  logic                en_i,
   output logic [CTR_BITS-1:0] ctr_o
);

   always_comb begin
      ctr_o = ctr_i;
      if (en_i) begin
         if (inc_i && (ctr_i != {CTR_BITS{1'b1}})) begin
            ctr_o = ctr_i + 1'b1;
         end else if (!inc_i && (ctr_i != '0)) begin
            ctr_o = ctr_i - 1'b1;
         end
      end
   end

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped dynamic branch predictor (saturating-counter BHT plus target BTB).
//   clk, rst                      : clock, synchronous active-high reset
//   pcF -> pred_hit/taken/target  : same-cycle fetch prediction
//   res_*                         : branch resolved in decode (valid, pc, outcome, old prediction)
//   mispredict/success            : check of the resolved branch against its prediction
//   redirect_pc                   : correct next PC for the resolved branch
//   ready                         : post-reset clearing sweep finished, table live
//   stat_branches/stat_mispred    : accepted resolve / mispredict counters (wrap mod 2**32)
module branch_predictor_bht
   import branch_predictor_bht_pkg::*;
#(
   parameter int unsigned IDX_BITS = 4,
   parameter int unsigned TAG_BITS = 8,
   parameter int unsigned CTR_BITS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pcF,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        res_valid,
   input  logic [31:0] res_pc,
   input  logic        res_taken,
   input  logic [31:0] res_target,
   input  logic        res_pred_taken,
   input  logic [31:0] res_pred_target,
   output logic        mispredict,
   output logic        success,
   output logic [31:0] redirect_pc,
   output logic        ready,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispred
);

   localparam int unsigned ENTRIES = 1 << IDX_BITS;
   localparam logic [CTR_BITS-1:0] CtrWeakT  = CTR_BITS'(ctr_weak_t(CTR_BITS));
   localparam logic [CTR_BITS-1:0] CtrWeakNt = CTR_BITS'(ctr_weak_nt(CTR_BITS));
   localparam logic [IDX_BITS-1:0] LastIdx   = IDX_BITS'(ENTRIES - 1);

   // Table storage; cleared by the sweep rather than by reset.
   logic                valid_q  [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

   bp_state_e           state_q, state_d;
   logic [IDX_BITS-1:0] init_idx_q, init_idx_d;
   logic [31:0]         stat_branches_q, stat_branches_d;
   logic [31:0]         stat_mispred_q, stat_mispred_d;

   logic [IDX_BITS-1:0] f_idx, r_idx;
   logic [TAG_BITS-1:0] f_tag, r_tag;
   logic                r_hit, wrong, accepted;
   logic [CTR_BITS-1:0] ctr_upd;

   assign ready = (state_q == StRun);

   // Fetch lookup
   assign f_idx       = pcF[IDX_BITS+1:2];
   assign f_tag       = pcF[IDX_BITS+2 +: TAG_BITS];
   assign pred_hit    = ready && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign pred_taken  = pred_hit && ctr_q[f_idx][CTR_BITS-1];
   assign pred_target = pred_taken ? target_q[f_idx] : (pcF + 32'd4);

   // Resolve check; independent of ready so decode can always flush.
   assign wrong       = (res_pred_taken != res_taken) ||
                        (res_taken && (res_pred_target != res_target));
   assign mispredict  = res_valid && wrong;
   assign success     = res_valid && !wrong;
   assign redirect_pc = res_taken ? res_target : (res_pc + 32'd4);

   assign r_idx    = res_pc[IDX_BITS+1:2];
   assign r_tag    = res_pc[IDX_BITS+2 +: TAG_BITS];
   assign r_hit    = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
   assign accepted = res_valid && ready;

   branch_predictor_bht_sat_counter #(
      .CTR_BITS(CTR_BITS)
   ) u_sat_counter (
      .ctr_i(ctr_q[r_idx]),
      .inc_i(res_taken),
      .en_i (r_hit),
      .ctr_o(ctr_upd)
   );

   always_comb begin
      state_d         = state_q;
      init_idx_d      = init_idx_q;
      stat_branches_d = stat_branches_q;
      stat_mispred_d  = stat_mispred_q;
      unique case (state_q)
         StInit: begin
            init_idx_d = init_idx_q + 1'b1;
            if (init_idx_q == LastIdx) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (accepted) begin
               stat_branches_d = stat_branches_q + 32'd1;
               if (wrong) begin
                  stat_mispred_d = stat_mispred_q + 32'd1;
               end
            end
         end
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= StInit;
         init_idx_q      <= '0;
         stat_branches_q <= '0;
         stat_mispred_q  <= '0;
      end else begin
         state_q         <= state_d;
         init_idx_q      <= init_idx_d;
         stat_branches_q <= stat_branches_d;
         stat_mispred_q  <= stat_mispred_d;
      end
   end

   // Table writes: sweep clear in INIT, training in RUN. A not-taken miss writes nothing.
   always_ff @(posedge clk) begin
      if (state_q == StInit) begin
         valid_q[init_idx_q] <= 1'b0;
         ctr_q[init_idx_q]   <= CtrWeakNt;
      end else if (accepted) begin
         if (r_hit) begin
            ctr_q[r_idx] <= ctr_upd;
            if (res_taken) begin
               target_q[r_idx] <= res_target;
            end
         end else if (res_taken) begin
            valid_q[r_idx]  <= 1'b1;
            tag_q[r_idx]    <= r_tag;
            target_q[r_idx] <= res_target;
            ctr_q[r_idx]    <= CtrWeakT;
         end
      end
   end

   assign stat_branches = stat_branches_q;
   assign stat_mispred  = stat_mispred_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht with a behavioural table model checked every cycle.
module tb_branch_predictor_bht;

   localparam int IDX_BITS = 4;
   localparam int TAG_BITS = 8;
   localparam int CTR_BITS = 2;
   localparam int ENTRIES  = 1 << IDX_BITS;
   localparam int CTR_MAX  = (1 << CTR_BITS) - 1;
   localparam int WEAK_T   = 1 << (CTR_BITS - 1);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pcF = 32'h100;
   logic        pred_hit, pred_taken;
   logic [31:0] pred_target;
   logic        res_valid = 1'b0;
   logic [31:0] res_pc = '0;
   logic        res_taken = 1'b0;
   logic [31:0] res_target = '0;
   logic        res_pred_taken = 1'b0;
   logic [31:0] res_pred_target = '0;
   logic        mispredict, success, ready;
   logic [31:0] redirect_pc, stat_branches, stat_mispred;

   branch_predictor_bht #(
      .IDX_BITS(IDX_BITS),
      .TAG_BITS(TAG_BITS),
      .CTR_BITS(CTR_BITS)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pcF            (pcF),
      .pred_hit       (pred_hit),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .res_valid      (res_valid),
      .res_pc         (res_pc),
      .res_taken      (res_taken),
      .res_target     (res_target),
      .res_pred_taken (res_pred_taken),
      .res_pred_target(res_pred_target),
      .mispredict     (mispredict),
      .success        (success),
      .redirect_pc    (redirect_pc),
      .ready          (ready),
      .stat_branches  (stat_branches),
      .stat_mispred   (stat_mispred)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_armed = 1'b0;
   int          m_init_left = 0;
   bit          m_valid [ENTRIES];
   int unsigned m_tag   [ENTRIES];
   logic [31:0] m_tgt   [ENTRIES];
   int          m_ctr   [ENTRIES];
   logic [31:0] m_br, m_mp;

   function automatic int unsigned idx_of(input logic [31:0] pc);
      return (pc >> 2) % ENTRIES;
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] pc);
      return (pc >> (IDX_BITS + 2)) % (1 << TAG_BITS);
   endfunction

   function automatic bit res_wrong();
      return (res_pred_taken != res_taken) || (res_taken && (res_pred_target != res_target));
   endfunction

   always @(posedge clk) begin
      int unsigned i;
      if (rst) begin
         m_armed     = 1'b1;
         m_init_left = ENTRIES;
         m_br        = '0;
         m_mp        = '0;
         for (int k = 0; k < ENTRIES; k++) begin
            m_valid[k] = 1'b0;
            m_ctr[k]   = WEAK_T - 1;
         end
      end else if (m_armed) begin
         if (m_init_left > 0) begin
            m_init_left--;
         end else if (res_valid) begin
            i = idx_of(res_pc);
            if (m_valid[i] && m_tag[i] == tag_of(res_pc)) begin
               if (res_taken) begin
                  m_ctr[i] = (m_ctr[i] < CTR_MAX) ? m_ctr[i] + 1 : CTR_MAX;
                  m_tgt[i] = res_target;
               end else begin
                  m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
               end
            end else if (res_taken) begin
               m_valid[i] = 1'b1;
               m_tag[i]   = tag_of(res_pc);
               m_tgt[i]   = res_target;
               m_ctr[i]   = WEAK_T;
            end
            m_br = m_br + 32'd1;
            if (res_wrong()) m_mp = m_mp + 32'd1;
         end
      end
   end

   always @(negedge clk) begin
      bit          rdy, hit, tk;
      int unsigned i;
      logic [31:0] tgt;
      if (m_armed) begin
         rdy = (m_init_left == 0);
         i   = idx_of(pcF);
         hit = rdy && m_valid[i] && (m_tag[i] == tag_of(pcF));
         tk  = hit && (m_ctr[i] >= WEAK_T);
         tgt = tk ? m_tgt[i] : pcF + 32'd4;
         chk("m_ready", ready, rdy);
         chk("m_pred_hit", pred_hit, hit);
         chk("m_pred_taken", pred_taken, tk);
         chk("m_pred_target", pred_target, tgt);
         chk("m_mispredict", mispredict, res_valid && res_wrong());
         chk("m_success", success, res_valid && !res_wrong());
         chk("m_redirect", redirect_pc, res_taken ? res_target : res_pc + 32'd4);
         chk("m_stat_branches", stat_branches, m_br);
         chk("m_stat_mispred", stat_mispred, m_mp);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
      res_valid       = 1'b1;
      res_pc          = pc;
      res_taken       = tk;
      res_target      = tgt;
      res_pred_taken  = ptk;
      res_pred_target = ptgt;
   endtask

   task automatic idle();
      res_valid = 1'b0;
   endtask

   initial begin
      // 1: reset, sweep length, empty-table prediction
      tick();
      tick();
      rst = 1'b0;
      for (int n = 0; n < ENTRIES; n++) begin
         mid();
         chk("init_ready_low", ready, 1'b0);
         tick();
      end
      mid();
      chk("ready_high", ready, 1'b1);
      chk("empty_hit", pred_hit, 1'b0);
      chk("empty_taken", pred_taken, 1'b0);
      chk("empty_target", pred_target, 32'h104);
      chk("reset_branches", stat_branches, 32'd0);

      // 2: first taken branch allocates
      tick();
      resolve(32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
      mid();
      chk("t2_mispredict", mispredict, 1'b1);
      chk("t2_redirect", redirect_pc, 32'h80);
      tick();
      idle();
      pcF = 32'h40;
      mid();
      chk("t2_hit", pred_hit, 1'b1);
      chk("t2_taken", pred_taken, 1'b1);
      chk("t2_target", pred_target, 32'h80);
      chk("t2_branches", stat_branches, 32'd1);
      chk("t2_mispred", stat_mispred, 32'd1);

      // 3: saturation up, down to zero, hold at zero
      tick();
      resolve(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
      mid();
      chk("t3_success", success, 1'b1);
      tick();
      resolve(32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
      mid();
      chk("t3_nt_mispredict", mispredict, 1'b1);
      chk("t3_nt_redirect", redirect_pc, 32'h44);
      tick();
      idle();
      mid();
      chk("t3_ctr2_taken", pred_taken, 1'b1);
      tick();
      resolve(32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
      tick();
      idle();
      mid();
      chk("t3_ctr1_hit", pred_hit, 1'b1);
      chk("t3_ctr1_taken", pred_taken, 1'b0);
      chk("t3_ctr1_target", pred_target, 32'h44);
      tick();
      resolve(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      tick();
      resolve(32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
      tick();
      idle();
      mid();
      chk("t3_hold0_taken", pred_taken, 1'b0);
      chk("t3_branches", stat_branches, 32'd7);
      chk("t3_mispred", stat_mispred, 32'd4);

      // 4: alias on idx 0
      pcF = 32'h80;
      #1;
      chk("t4_alias_miss", pred_hit, 1'b0);
      tick();
      resolve(32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
      tick();
      idle();
      pcF = 32'h40;
      #1;
      chk("t4_old_evicted", pred_hit, 1'b0);
      pcF = 32'h80;
      #1;
      chk("t4_new_hit", pred_hit, 1'b1);
      chk("t4_new_target", pred_target, 32'h200);

      // 5: same-cycle lookup and update sees old contents
      resolve(32'h40, 1'b1, 32'h300, 1'b0, 32'h44);
      pcF = 32'h40;
      mid();
      chk("t5_no_bypass_hit", pred_hit, 1'b0);
      chk("t5_no_bypass_target", pred_target, 32'h44);
      tick();
      idle();
      mid();
      chk("t5_after_hit", pred_hit, 1'b1);
      chk("t5_after_target", pred_target, 32'h300);

      // 7: right direction, wrong target
      tick();
      resolve(32'h40, 1'b1, 32'h500, 1'b1, 32'h300);
      mid();
      chk("t7_tgt_mispredict", mispredict, 1'b1);
      chk("t7_tgt_success", success, 1'b0);
      tick();
      idle();
      mid();
      chk("t7_retarget", pred_target, 32'h500);

      // 6: reset mid-run; resolves during the sweep are ignored
      tick();
      rst = 1'b1;
      resolve(32'h40, 1'b0, 32'h0, 1'b1, 32'h300);
      tick();
      rst = 1'b0;
      for (int n = 0; n < ENTRIES; n++) begin
         mid();
         chk("t6_ready_low", ready, 1'b0);
         chk("t6_branches_init", stat_branches, 32'd0);
         tick();
      end
      idle();
      mid();
      chk("t6_ready_high", ready, 1'b1);
      chk("t6_cleared_hit", pred_hit, 1'b0);
      chk("t6_branches", stat_branches, 32'd0);
      chk("t6_mispred", stat_mispred, 32'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
